// File: rtl/reg_dump_streamer_if.sv
// -----------------------------------------------------------------------------
// reg_dump_streamer_if
// Word stream from the register dump engine toward the debug/trace path.
//   out_valid  : out_data, out_idx and out_last are valid
//   out_ready  : downstream accepts the word this cycle
//   out_data   : captured register value
//   out_idx    : register index of out_data
//   out_last   : final word of the requested range
// Modports: master (streamer side), slave (trace sink side).
// -----------------------------------------------------------------------------
interface reg_dump_streamer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_streamer.sv
// -----------------------------------------------------------------------------
// reg_dump_streamer
// Debug read-out engine for the integer register file. Walks the inclusive
// index range [first_idx, last_idx] on a dedicated read port, captures each
// word and streams it out over a valid/ready interface. It never writes the
// register file.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   start             : begin a dump (sampled only in IDLE)
//   first_idx/last_idx: inclusive range, sampled with start
//   abort             : cancel the dump in progress (READ/SEND only)
//   rf_addr / rf_data : register-file read port (combinational data)
//   stream            : word stream (out_valid/out_ready/out_data/out_idx/out_last)
//   busy              : not IDLE
//   done              : one-cycle pulse on normal completion
//   err               : pulses with done when the requested range was empty
// -----------------------------------------------------------------------------
module reg_dump_streamer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_idx,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                abort,
    output logic [ADDR_W-1:0]   rf_addr,
    input  logic [DATA_W-1:0]   rf_data,
    reg_dump_streamer_if.master stream,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX = ADDR_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [ADDR_W-1:0] index_r;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] rf_addr_r;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] idx_r;
    logic              last_flag_r;
    logic              valid_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              err_nx_s;
    logic [ADDR_W-1:0] last_clamp_s;
    logic              range_empty_s;
    logic              accept_s;

    assign accept_s = valid_r & stream.out_ready;

    // Limit the requested end index to the last architectural register.
    always_comb begin
        last_clamp_s = last_idx;
        if (last_idx > MAX_IDX) begin
            last_clamp_s = MAX_IDX;
        end else begin
            last_clamp_s = last_idx;
        end
        range_empty_s = (first_idx > last_clamp_s);
    end

    // Next-state selection; abort outranks a same-cycle handshake.
    always_comb begin
        state_nx_s = state_r;
        err_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (range_empty_s) begin
                        state_nx_s = ST_FIN;
                        err_nx_s   = 1'b1;
                    end else begin
                        state_nx_s = ST_READ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (accept_s) begin
                    if (last_flag_r) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s = ST_READ;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, read address, capture register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            index_r     <= '0;
            last_r      <= '0;
            rf_addr_r   <= '0;
            data_r      <= '0;
            idx_r       <= '0;
            last_flag_r <= 1'b0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            // Status flags describe the state being entered, so they line up with it.
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_FIN);
            err_r   <= err_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (start && !range_empty_s) begin
                        last_r    <= last_clamp_s;
                        index_r   <= first_idx;
                        rf_addr_r <= first_idx;
                    end else begin
                        rf_addr_r <= '0;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        valid_r   <= 1'b0;
                        rf_addr_r <= '0;
                    end else begin
                        data_r      <= rf_data;
                        idx_r       <= index_r;
                        last_flag_r <= (index_r == last_r);
                        valid_r     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        valid_r   <= 1'b0;
                        rf_addr_r <= '0;
                    end else if (accept_s) begin
                        valid_r <= 1'b0;
                        // No wrap: the index only advances while below the last index.
                        if (!last_flag_r) begin
                            index_r   <= index_r + ONE_IDX;
                            rf_addr_r <= index_r + ONE_IDX;
                        end else begin
                            rf_addr_r <= rf_addr_r;
                        end
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                ST_FIN: begin
                    rf_addr_r <= '0;
                end
                default: begin
                    valid_r   <= 1'b0;
                    rf_addr_r <= '0;
                end
            endcase
        end
    end

    assign rf_addr          = rf_addr_r;
    assign stream.out_valid = valid_r;
    assign stream.out_data  = data_r;
    assign stream.out_idx   = idx_r;
    assign stream.out_last  = last_flag_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;

endmodule

// File: tb/tb_reg_dump_streamer.sv
module tb_reg_dump_streamer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              abort;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              busy;
    logic              done;
    logic              err;

    reg_dump_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) stream_if ();

    reg_dump_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .stream    (stream_if),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Register file stub: index 0 reads as zero, others 0x1000_0000 + index.
    function automatic logic [31:0] rf_word(input logic [4:0] a);
        if (a == 5'd0) return 32'h0000_0000;
        return 32'h1000_0000 + {27'd0, a};
    endfunction

    assign rf_data = rf_word(rf_addr);

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  got_idx[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    int          done_cnt, err_cnt, done_cyc, err_cyc, first_valid_cyc, end_cyc, unstable_cnt;
    bit          timed_out, aborted;
    logic        abort_valid_after, abort_busy_after;

    task automatic kick(input logic [4:0] f, input logic [4:0] l, input logic ab);
        @(negedge clk);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        abort     = ab;
    endtask

    // Runs one dump (start already driven) and records what the stream produced.
    task automatic collect(input int stall, input int abort_at, input bit repulse, input int max_cyc);
        int          cyc = 0;
        int          wait_cnt = 0;
        bit          prev_hold = 1'b0;
        bit          fin = 1'b0;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        got_idx.delete(); got_data.delete(); got_last.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
        first_valid_cyc = -1; end_cyc = -1; unstable_cnt = 0;
        timed_out = 1'b0; aborted = 1'b0;
        abort_valid_after = 1'bx; abort_busy_after = 1'bx;
        pd = 32'h0; pi = 5'd0; pl = 1'b0;
        stream_if.out_ready = (stall == 0);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin start = 1'b0; abort = 1'b0; end
            if (repulse && cyc == 3) begin first_idx = 5'd20; last_idx = 5'd25; start = 1'b1; end
            if (repulse && cyc == 4) start = 1'b0;
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (err) begin err_cnt++; err_cyc = cyc; end
            if (aborted) begin
                abort_valid_after = stream_if.out_valid;
                abort_busy_after  = busy;
                abort   = 1'b0;
                end_cyc = cyc;
                fin     = 1'b1;
            end else if (!busy && cyc > 1) begin
                end_cyc = cyc;
                fin     = 1'b1;
            end else if (cyc >= max_cyc) begin
                timed_out = 1'b1;
                fin       = 1'b1;
            end else if (stream_if.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_hold && (stream_if.out_data !== pd || stream_if.out_idx !== pi ||
                                  stream_if.out_last !== pl)) unstable_cnt++;
                if (abort_at >= 0 && int'(stream_if.out_idx) == abort_at) begin
                    abort = 1'b1;
                    stream_if.out_ready = 1'b1;
                    aborted   = 1'b1;
                    prev_hold = 1'b0;
                end else begin
                    stream_if.out_ready = (wait_cnt >= stall);
                    if (stream_if.out_ready) begin
                        got_idx.push_back(stream_if.out_idx);
                        got_data.push_back(stream_if.out_data);
                        got_last.push_back(stream_if.out_last);
                        wait_cnt  = 0;
                        prev_hold = 1'b0;
                    end else begin
                        wait_cnt++;
                        prev_hold = 1'b1;
                        pd = stream_if.out_data;
                        pi = stream_if.out_idx;
                        pl = stream_if.out_last;
                    end
                end
            end else begin
                stream_if.out_ready = (stall == 0);
                prev_hold = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        stream_if.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = 5'd0; last_idx = 5'd0; stream_if.out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({rf_addr, stream_if.out_valid, stream_if.out_data, stream_if.out_idx,
             stream_if.out_last, busy, done, err} !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b err=%b, expected all 0",
                     rf_addr, stream_if.out_valid, stream_if.out_data, stream_if.out_idx,
                     stream_if.out_last, busy, done, err);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, stream_if.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b valid=%b, expected 0 0", busy, stream_if.out_valid);
        end
    endtask

    task automatic test_full_range();
        logic [4:0] e_idx;
        kick(5'd0, 5'd31, 1'b0);
        collect(0, -1, 1'b0, 200);
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got timeout, expected completion"); end
        n_checks++;
        if (got_idx.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d expected 32", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 32; i++) begin
            e_idx = 5'(i);
            n_checks++;
            if (got_idx[i] !== e_idx) begin n_fail++; $display("FAIL full_idx[%0d]: got %0d expected %0d", i, got_idx[i], e_idx); end
            n_checks++;
            if (got_data[i] !== rf_word(e_idx)) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, got_data[i], rf_word(e_idx)); end
            n_checks++;
            if (got_last[i] !== (i == 31)) begin n_fail++; $display("FAIL full_last[%0d]: got %b expected %b", i, got_last[i], (i == 31)); end
        end
        if (got_data.size() > 5) begin
            n_checks++;
            if (got_data[0] !== 32'h0000_0000) begin n_fail++; $display("FAIL full_word0: got %h expected 00000000", got_data[0]); end
            n_checks++;
            if (got_data[5] !== 32'h1000_0005) begin n_fail++; $display("FAIL full_word5: got %h expected 10000005", got_data[5]); end
        end
        n_checks++;
        if (first_valid_cyc != 2) begin n_fail++; $display("FAIL full_latency: got %0d expected 2", first_valid_cyc); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++;
        if (done_cyc - first_valid_cyc + 1 != 64) begin
            n_fail++; $display("FAIL full_done_time: got %0d expected 64", done_cyc - first_valid_cyc + 1);
        end
        n_checks++;
        if (err_cnt != 0) begin n_fail++; $display("FAIL full_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_stall();
        kick(5'd5, 5'd7, 1'b0);
        collect(3, -1, 1'b0, 200);
        n_checks++;
        if (got_idx.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 3; i++) begin
            n_checks++;
            if (got_data[i] !== 32'h1000_0005 + 32'(i)) begin
                n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], 32'h1000_0005 + 32'(i));
            end
            n_checks++;
            if (got_last[i] !== (i == 2)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", i, got_last[i], (i == 2)); end
        end
        n_checks++;
        if (unstable_cnt != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", unstable_cnt); end
        n_checks++;
        if (done_cnt != 1 || end_cyc != done_cyc + 1) begin
            n_fail++; $display("FAIL stall_busy_drop: got done_cnt=%0d done_cyc=%0d idle_cyc=%0d, expected 1 and idle one cycle after done",
                               done_cnt, done_cyc, end_cyc);
        end
    endtask

    task automatic test_empty_range();
        kick(5'd9, 5'd3, 1'b0);
        collect(0, -1, 1'b0, 50);
        n_checks++;
        if (first_valid_cyc != -1) begin n_fail++; $display("FAIL empty_no_valid: got valid at cycle %0d expected none", first_valid_cyc); end
        n_checks++;
        if (done_cyc != 1 || err_cyc != 1 || done_cnt != 1 || err_cnt != 1) begin
            n_fail++; $display("FAIL empty_done_err: got done_cyc=%0d err_cyc=%0d counts=%0d/%0d expected 1 1 1/1",
                               done_cyc, err_cyc, done_cnt, err_cnt);
        end
    endtask

    task automatic test_abort();
        kick(5'd0, 5'd31, 1'b0);
        collect(0, 10, 1'b0, 200);
        n_checks++;
        if (got_idx.size() != 10 || aborted !== 1'b1) begin
            n_fail++; $display("FAIL abort_count: got %0d words aborted=%b expected 10 and 1", got_idx.size(), aborted);
        end
        n_checks++;
        if ({abort_valid_after, abort_busy_after} !== 2'b00) begin
            n_fail++; $display("FAIL abort_idle: got valid=%b busy=%b expected 0 0", abort_valid_after, abort_busy_after);
        end
        n_checks++;
        if (done_cnt != 0 || err_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got done=%0d err=%0d expected 0 0", done_cnt, err_cnt); end
        kick(5'd2, 5'd2, 1'b0);
        collect(0, -1, 1'b0, 50);
        n_checks++;
        if (got_idx.size() != 1) begin n_fail++; $display("FAIL abort_restart_count: got %0d expected 1", got_idx.size()); end
        else begin
            n_checks++;
            if ({got_idx[0], got_data[0], got_last[0]} !== {5'd2, 32'h1000_0002, 1'b1}) begin
                n_fail++; $display("FAIL abort_restart_word: got idx=%0d d=%h l=%b expected 2 10000002 1", got_idx[0], got_data[0], got_last[0]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        kick(5'd0, 5'd31, 1'b0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (stream_if.out_valid && stream_if.out_idx == 5'd4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL areset_reach_idx4: got no idx 4 expected idx 4 within 40 cycles"); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({rf_addr, stream_if.out_valid, stream_if.out_data, stream_if.out_idx,
             stream_if.out_last, busy, done, err} !== 73'd0) begin
            n_fail++; $display("FAIL areset_outputs: got addr=%0d v=%b d=%h i=%0d busy=%b, expected all 0",
                               rf_addr, stream_if.out_valid, stream_if.out_data, stream_if.out_idx, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        // start and abort together in IDLE: start must win
        kick(5'd31, 5'd31, 1'b1);
        collect(0, -1, 1'b0, 50);
        n_checks++;
        if (got_idx.size() != 1) begin n_fail++; $display("FAIL areset_restart_count: got %0d expected 1", got_idx.size()); end
        else begin
            n_checks++;
            if ({got_idx[0], got_data[0], got_last[0]} !== {5'd31, 32'h1000_001F, 1'b1}) begin
                n_fail++; $display("FAIL areset_restart_word: got idx=%0d d=%h l=%b expected 31 1000001f 1", got_idx[0], got_data[0], got_last[0]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL areset_restart_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        kick(5'd0, 5'd3, 1'b0);
        collect(0, -1, 1'b1, 100);
        n_checks++;
        if (got_idx.size() != 4) begin n_fail++; $display("FAIL rebusy_count: got %0d expected 4", got_idx.size()); end
        for (int i = 0; i < got_idx.size() && i < 4; i++) begin
            n_checks++;
            if (got_idx[i] !== 5'(i)) begin n_fail++; $display("FAIL rebusy_idx[%0d]: got %0d expected %0d", i, got_idx[i], i); end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL rebusy_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_stall();
        test_empty_range();
        test_abort();
        test_async_reset();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
